// File: rtl/hba_pkg.sv
// Shared definitions for the HBA bus master: FSM state encoding and default bus widths.
package hba_pkg;

  localparam int HBA_DBUS_WIDTH = 8;
  localparam int HBA_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } hba_state_e;

endpackage

// File: rtl/hba_master.sv
// HBA bus master: accepts one command at a time, arbitrates for the bus, runs one transfer.
// Optional XFER timeout is enabled by defining HBA_MASTER_TIMEOUT_EN.
module hba_master
  import hba_pkg::*;
#(
  parameter int DBUS_WIDTH     = HBA_DBUS_WIDTH,
  parameter int ADDR_WIDTH     = HBA_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rnw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DBUS_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DBUS_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  hba_mrequest,
  input  logic                  hba_mgrant,
  output logic                  hba_select,
  output logic                  hba_rnw,
  output logic [ADDR_WIDTH-1:0] hba_abus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_mstr,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  input  logic                  hba_xferack
);

  hba_state_e state_q, state_d;

  logic                  cmd_rnw_q, cmd_rnw_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DBUS_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

  logic                  cmd_ready_d;
  logic                  rsp_valid_d;
  logic [DBUS_WIDTH-1:0] rsp_rdata_d;
  logic                  rsp_err_d;
  logic                  mrequest_d;
  logic                  select_d;
  logic                  rnw_d;
  logic [ADDR_WIDTH-1:0] abus_d;
  logic [DBUS_WIDTH-1:0] dbus_mstr_d;
  logic                  timeout;

`ifdef HBA_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] xfer_cnt;

  // Counts completed XFER cycles; reads as zero on the first XFER cycle.
  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      xfer_cnt <= '0;
    end else if (state_q == XFER) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end else begin
      xfer_cnt <= '0;
    end
  end

  assign timeout = (state_q == XFER) && (xfer_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_rnw_d   = cmd_rnw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_rnw_d   = cmd_rnw;
          cmd_addr_d  = cmd_addr;
          cmd_wdata_d = cmd_wdata;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (hba_mgrant) begin
          state_d = XFER;
        end
      end
      XFER: begin
        // An ack wins over a timeout landing on the same cycle.
        if (hba_xferack) begin
          rsp_rdata_d = cmd_rnw_q ? hba_dbus : '0;
          rsp_err_d   = 1'b0;
          state_d     = DONE;
        end else if (timeout) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    cmd_ready_d = (state_d == IDLE);
    mrequest_d  = (state_d == REQ) || (state_d == XFER);
    select_d    = (state_d == XFER);
    rnw_d       = select_d && cmd_rnw_d;
    abus_d      = select_d ? cmd_addr_d : '0;
    dbus_mstr_d = (select_d && !cmd_rnw_d) ? cmd_wdata_d : '0;
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q       <= IDLE;
      cmd_rnw_q     <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      hba_mrequest  <= 1'b0;
      hba_select    <= 1'b0;
      hba_rnw       <= 1'b0;
      hba_abus      <= '0;
      hba_dbus_mstr <= '0;
    end else begin
      state_q       <= state_d;
      cmd_rnw_q     <= cmd_rnw_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      cmd_ready     <= cmd_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_err       <= rsp_err_d;
      hba_mrequest  <= mrequest_d;
      hba_select    <= select_d;
      hba_rnw       <= rnw_d;
      hba_abus      <= abus_d;
      hba_dbus_mstr <= dbus_mstr_d;
    end
  end

endmodule

// File: doc/hba_master.md
HBA_MASTER -- requirements
Module: hba_master

Interface
REQ-001 SHALL have parameter DBUS_WIDTH, default 8, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, full HBA address (4-bit periph + 8-bit reg).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles in XFER awaiting ack (used only with timeout feature).
REQ-004 SHALL have one clock and a synchronous, active-high reset: hba_clk in 1 (clock); hba_reset in 1 (reset).
REQ-005 SHALL have ports:
- cmd_valid in 1: command offered.
- cmd_ready out 1: command accepted when valid&ready.
- cmd_rnw in 1: 1=read, 0=write.
- cmd_addr in ADDR_WIDTH: target address.
- cmd_wdata in DBUS_WIDTH: write data.
- rsp_valid out 1: one-cycle response pulse.
- rsp_rdata out DBUS_WIDTH: read data.
- rsp_err out 1: transfer timed out.
- hba_mrequest out 1: bus request to arbiter.
- hba_mgrant in 1: bus granted.
- hba_select out 1: transfer in progress.
- hba_rnw out 1: bus direction.
- hba_abus out ADDR_WIDTH: address.
- hba_dbus_mstr out DBUS_WIDTH: write data.
- hba_dbus in DBUS_WIDTH: ORed slave read data.
- hba_xferack in 1: ORed slave acknowledge.

Function
REQ-006 FSM states IDLE, REQ, XFER, DONE; all outputs registered.
REQ-007 IDLE: cmd_ready=1, all bus outputs 0; on cmd_valid latch rnw/addr/wdata, go REQ next cycle.
REQ-008 cmd_ready SHALL be 0 in every state except IDLE; exactly one command outstanding.
REQ-009 REQ: hba_mrequest=1; on hba_mgrant=1 go XFER next cycle; wait indefinitely otherwise.
REQ-010 XFER: hba_select=1, hba_rnw/hba_abus driven from latched command; hba_dbus_mstr=wdata for writes, 0 for reads; hba_mrequest held 1.
REQ-011 Grant loss during XFER SHALL NOT abort the transfer.
REQ-012 XFER with hba_xferack=1: capture hba_dbus into rsp_rdata if read (0 if write); go DONE next cycle.
REQ-013 DONE: hba_select, hba_mrequest, hba_abus, hba_rnw, hba_dbus_mstr all 0; rsp_valid=1 for exactly this cycle; go IDLE.
REQ-014 Command-to-select latency with grant already high: 2 cycles (accept edge, REQ, XFER).
REQ-015 Bus outputs SHALL be 0 whenever hba_select=0 (ORed bus requirement).
REQ-016 hba_xferack seen outside XFER SHALL be ignored.
REQ-017 rsp_rdata and rsp_err SHALL hold value until next rsp_valid.

Reset
REQ-018 On hba_reset (including mid-transfer) next state IDLE; every output 0 except cmd_ready=1 after first post-reset cycle; latched command discarded, no rsp_valid issued.

Configuration
REQ-019 Macro HBA_MASTER_TIMEOUT_EN defined: XFER cycle counter (width clog2(TIMEOUT_CYCLES+1)) cleared on XFER entry; reaching TIMEOUT_CYCLES without ack ends XFER, DONE issues rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-020 Macro undefined: no counter; XFER waits for ack forever; rsp_err tied 0.
REQ-021 Ack in the same cycle as timeout SHALL count as success (rsp_err=0).

Structure
REQ-022 Shared package hba_pkg SHALL hold FSM state encoding and default DBUS/ADDR widths.
REQ-023 Single flat module; no sub-module required.

Verification
REQ-024 Write addr 0x201 data 0x35, grant high, slave acks in 3rd XFER cycle -> select high 3 cycles, abus=0x201, dbus_mstr=0x35, rsp_valid 1 cycle, rsp_err=0.
REQ-025 Read addr 0x102, slave drives 0xA5 with ack -> rsp_rdata=0xA5, dbus_mstr=0 throughout.
REQ-026 Grant withheld 10 cycles -> mrequest high 10 cycles, select 0 until cycle after grant.
REQ-027 TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> select high 4 cycles, rsp_err=1, rsp_rdata=0.
REQ-028 Reset asserted in XFER -> select 0 next cycle, no rsp_valid, cmd_ready=1 afterwards.
REQ-029 Back-to-back cmd_valid held high -> second command accepted only in IDLE following DONE.
